tblink_rpc_tip_unpack: RTL

- Consumes the 8-bit ready/valid byte stream on the endpoint's target-interface output (tipo) and parses it into packets.
- Packet format: byte0 = dst address, byte1 = payload length N (0..255), then N payload bytes.
- Emits payload as 32-bit little-endian words with first/last framing and per-packet header fields.
- Sits directly downstream of tblink_rpc_ep; feeds target-side message logic.

---
 rtl/tblink_rpc_tip_unpack.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tblink_rpc_tip_unpack.sv
// Parses the endpoint's tipo byte stream (dst, len, payload) into 32-bit little-endian
// message beats with first/last framing, optional dst filtering and a saturating drop counter.
module tblink_rpc_tip_unpack #(
  parameter logic [7:0] ADDR      = 8'h01,
  parameter bit         FILTER_EN = 1'b1
) (
  input  logic        uclock,
  input  logic        reset,
  input  logic [7:0]  tipo_dat,
  input  logic        tipo_valid,
  output logic        tipo_ready,
  output logic [31:0] msg_dat,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic        msg_first,
  output logic        msg_last,
  output logic [2:0]  msg_nbytes,
  output logic [7:0]  msg_dst,
  output logic [7:0]  msg_len,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {StHdrDst, StHdrLen, StPayload, StDiscard} state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [7:0]  dst_q, dst_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic        first_q, first_d;
  logic [15:0] drop_q, drop_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_dat_q, out_dat_d;
  logic        out_first_q, out_first_d;
  logic        out_last_q, out_last_d;
  logic [2:0]  out_nbytes_q, out_nbytes_d;
  logic [7:0]  out_dst_q, out_dst_d;
  logic [7:0]  out_len_q, out_len_d;

  logic        accept;
  logic        match;
  logic [15:0] drop_sat;
  logic [31:0] word;

  // run_q keeps the input closed while in reset and for the first edge after it.
  assign tipo_ready = run_q && !(out_valid_q && !msg_ready);
  assign accept     = tipo_valid && tipo_ready;
  assign match      = (dst_q == ADDR) || !FILTER_EN;
  assign drop_sat   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    dst_d        = dst_q;
    len_d        = len_q;
    rem_d        = rem_q;
    lane_d       = lane_q;
    acc_d        = acc_q;
    first_d      = first_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q && !msg_ready;
    out_dat_d    = out_dat_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_nbytes_d = out_nbytes_q;
    out_dst_d    = out_dst_q;
    out_len_d    = out_len_q;
    // Upper lanes stay zero because the accumulator is cleared after every beat.
    word         = {8'h00, acc_q};
    word[{lane_q, 3'b000} +: 8] = tipo_dat;

    if (accept) begin
      case (state_q)
        StHdrDst: begin
          dst_d   = tipo_dat;
          state_d = StHdrLen;
        end
        StHdrLen: begin
          len_d   = tipo_dat;
          rem_d   = tipo_dat;
          lane_d  = 2'd0;
          acc_d   = 24'd0;
          first_d = 1'b1;
          if (match) begin
            if (tipo_dat == 8'd0) begin
              out_valid_d  = 1'b1;
              out_dat_d    = 32'd0;
              out_nbytes_d = 3'd0;
              out_first_d  = 1'b1;
              out_last_d   = 1'b1;
              out_dst_d    = dst_q;
              out_len_d    = 8'd0;
              state_d      = StHdrDst;
            end else begin
              state_d = StPayload;
            end
          end else if (tipo_dat == 8'd0) begin
            drop_d  = drop_sat;
            state_d = StHdrDst;
          end else begin
            state_d = StDiscard;
          end
        end
        StPayload: begin
          rem_d  = rem_q - 8'd1;
          lane_d = lane_q + 2'd1;
          acc_d  = word[23:0];
          if (lane_q == 2'd3 || rem_q == 8'd1) begin
            out_valid_d  = 1'b1;
            out_dat_d    = word;
            out_nbytes_d = {1'b0, lane_q} + 3'd1;
            out_first_d  = first_q;
            out_last_d   = (rem_q == 8'd1);
            out_dst_d    = dst_q;
            out_len_d    = len_q;
            acc_d        = 24'd0;
            first_d      = 1'b0;
          end
          if (rem_q == 8'd1) begin
            lane_d  = 2'd0;
            state_d = StHdrDst;
          end
        end
        StDiscard: begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            drop_d  = drop_sat;
            state_d = StHdrDst;
          end
        end
        default: state_d = StHdrDst;
      endcase
    end
  end

  always_ff @(posedge uclock or negedge reset) begin
    if (!reset) begin
      state_q      <= StHdrDst;
      run_q        <= 1'b0;
      dst_q        <= 8'd0;
      len_q        <= 8'd0;
      rem_q        <= 8'd0;
      lane_q       <= 2'd0;
      acc_q        <= 24'd0;
      first_q      <= 1'b0;
      drop_q       <= 16'd0;
      out_valid_q  <= 1'b0;
      out_dat_q    <= 32'd0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_nbytes_q <= 3'd0;
      out_dst_q    <= 8'd0;
      out_len_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      dst_q        <= dst_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      first_q      <= first_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_dat_q    <= out_dat_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_nbytes_q <= out_nbytes_d;
      out_dst_q    <= out_dst_d;
      out_len_q    <= out_len_d;
    end
  end

  assign msg_valid  = out_valid_q;
  assign msg_dat    = out_dat_q;
  assign msg_first  = out_first_q;
  assign msg_last   = out_last_q;
  assign msg_nbytes = out_nbytes_q;
  assign msg_dst    = out_dst_q;
  assign msg_len    = out_len_q;
  assign drop_cnt   = drop_q;

endmodule
